mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LAT, default 2, memory read latency in cycles after the ACCESS cycle (legal range 1..15).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 32, data width.
REQ-004 SHALL have port clk  input  1  the single clock; all logic rising-edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_req  input  1  fetch request; held with i_addr until i_ready.
REQ-007 SHALL have port i_addr  input  AW  fetch address.
REQ-008 SHALL have port i_rdata  output  DW  fetched word, valid while i_ready=1.
REQ-009 SHALL have port i_ready  output  1  one-cycle fetch-completion pulse.
REQ-010 SHALL have port d_req  input  1  data request; held with d_we, d_addr and d_wdata until d_ready.
REQ-011 SHALL have port d_we  input  1  1 = store, 0 = load.
REQ-012 SHALL have port d_addr  input  AW  data address.
REQ-013 SHALL have port d_wdata  input  DW  store data.
REQ-014 SHALL have port d_rdata  output  DW  load data, valid while d_ready=1.
REQ-015 SHALL have port d_ready  output  1  one-cycle data-completion pulse.
REQ-016 SHALL have port m_en  output  1  memory access strobe.
REQ-017 SHALL have port m_we  output  1  memory write enable.
REQ-018 SHALL have port m_addr  output  AW  memory address.
REQ-019 SHALL have port m_wdata  output  DW  memory write data.
REQ-020 SHALL have port m_rdata  input  DW  memory read data, valid LAT cycles after the m_en cycle.

Function
REQ-021 SHALL implement the FSM IDLE -> ACCESS -> WAIT -> RESP -> IDLE.
REQ-022 SHALL, in IDLE with any request, grant one port, latch its address, we and wdata, and go to ACCESS; with no request it SHALL stay in IDLE.
REQ-023 SHALL grant the sole requester when only one port requests.
REQ-024 SHALL, when both ports request, grant the port not granted last; last_grant resets to I, so D wins the first tie.
REQ-025 SHALL, in ACCESS (exactly one cycle), drive m_en=1, m_we = latched we (fetch: 0), m_addr and m_wdata from the latches.
REQ-026 SHALL hold m_en=0 and m_we=0 in all other states; m_addr and m_wdata SHALL be 0 outside ACCESS.
REQ-027 SHALL, in WAIT, run for exactly LAT cycles using a down-counter loaded with LAT-1, and capture m_rdata into the granted port's rdata register on the last WAIT cycle.
REQ-028 SHALL, in RESP (one cycle), assert the granted port's ready; the other port's ready SHALL stay 0.
REQ-029 SHALL hold the rdata registers until the next capture; a store does not update d_rdata.
REQ-030 SHALL, for a grant in IDLE at cycle T, complete with ready at T+2+LAT and be IDLE again at T+3+LAT, so the back-to-back period is LAT+3.
REQ-031 SHALL sample a req held high in IDLE after RESP as a new request.
REQ-032 SHALL ignore req and address changes during ACCESS, WAIT and RESP; the in-flight transaction completes with latched values even if req drops.

Reset
REQ-033 SHALL, with rst=1 at a rising edge, set the state to IDLE, last_grant to I, the counter to 0, and the rdata registers to 0.
REQ-034 SHALL drive all outputs to 0 in the cycle after reset.
REQ-035 SHALL, on reset mid-transaction, drop the in-flight access, never pulse its ready, and serve the first request after rst falls normally.

Structure
REQ-036 SHALL place the FSM state encodings (IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, RESP=2'd3) and the grant encoding (GNT_I=0, GNT_D=1) in the shared package rv_pkg.
REQ-037 SHALL be a single module with no sub-module; the latency counter is inline.

Verification (LAT=2 unless stated; T = grant cycle)
REQ-038 SHALL cover: fetch at 0x0, memory model returns 0x00500113 -> m_en=1 at T+1 only; i_ready=1 and i_rdata=0x00500113 at T+4; d_ready stays 0.
REQ-039 SHALL cover: store d_addr=0x68, d_wdata=0x19 -> at T+1 m_en=1, m_we=1, m_addr=0x68, m_wdata=0x19; d_ready at T+4; d_rdata unchanged.
REQ-040 SHALL cover: i_req and d_req rise together after reset -> D granted first, d_ready at T+4; I granted at T+5 with i_ready at T+9.
REQ-041 SHALL cover: both requests held continuously for 4 transactions -> grant order D, I, D, I with ready pulses 5 cycles apart.
REQ-042 SHALL cover: rst pulsed during WAIT -> all outputs 0 next cycle, no ready pulse; a fetch issued after reset completes normally at T+4.
REQ-043 SHALL cover: LAT=1, load from 0x60 -> m_en at T+1, d_ready with the model data at T+3.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared encodings for the memory arbiter: FSM states, grant owner and
// the fixed-priority-with-alternation grant selection.
package rv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arbStateT;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grantT;

  localparam int unsigned CNT_W = 4;

  // On a tie the port that did not win last time is served.
  function automatic grantT pickGrant(input logic iReq, input logic dReq,
                                      input grantT lastGrant);
    if (iReq && dReq) begin
      return (lastGrant == GNT_I) ? GNT_D : GNT_I;
    end else if (dReq) begin
      return GNT_D;
    end
    return GNT_I;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one fixed-latency memory port.
// One transaction at a time: IDLE -> ACCESS -> WAIT (LAT cycles) -> RESP.
module mem_arbiter
  import rv_pkg::*;
#(
  parameter int unsigned LAT = 2,
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  arbStateT            state;
  arbStateT            nextState;
  grantT               lastGrant;
  grantT               sel;
  logic [AW-1:0]       latAddr;
  logic                latWe;
  logic [DW-1:0]       latWdata;
  logic [CNT_W-1:0]    cnt;
  logic [DW-1:0]       iRdataReg;
  logic [DW-1:0]       dRdataReg;

  always_comb begin
    sel = pickGrant(i_req, d_req, lastGrant);
  end

  // lastGrant doubles as the owner of the in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lastGrant <= GNT_I;
      latAddr   <= '0;
      latWe     <= 1'b0;
      latWdata  <= '0;
      cnt       <= '0;
      iRdataReg <= '0;
      dRdataReg <= '0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            lastGrant <= sel;
            latAddr   <= (sel == GNT_D) ? d_addr : i_addr;
            latWe     <= (sel == GNT_D) && d_we;
            latWdata  <= (sel == GNT_D) ? d_wdata : '0;
          end
        end
        ACCESS: cnt <= CNT_W'(LAT - 1);
        WAIT: begin
          if (cnt == '0) begin
            if (lastGrant == GNT_D) begin
              if (!latWe) begin
                dRdataReg <= m_rdata;
              end
            end else begin
              iRdataReg <= m_rdata;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (i_req || d_req) nextState = ACCESS;
      ACCESS:  nextState = WAIT;
      WAIT:    if (cnt == '0) nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    i_ready = 1'b0;
    d_ready = 1'b0;
    case (state)
      ACCESS: begin
        m_en    = 1'b1;
        m_we    = latWe;
        m_addr  = latAddr;
        m_wdata = latWdata;
      end
      RESP: begin
        i_ready = (lastGrant == GNT_I);
        d_ready = (lastGrant == GNT_D);
      end
      default: ;
    endcase
  end

  assign i_rdata = iRdataReg;
  assign d_rdata = dRdataReg;

endmodule
